// File: rtl/dequantizer_top.sv
`default_nettype none
// ============================================================================
// Module      : dequantizer_top
// Description : Rescales a block of signed int8 values by the block max_num
//               scale, LANES elements per cycle, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module dequantizer_top #(
    parameter int IN_WIDTH       = 8,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int MAX_NUM_WIDTH  = 16,
    parameter int OUT_WIDTH      = 16,
    parameter int LANES          = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [IN_PARALLELISM*IN_SIZE*IN_WIDTH-1:0]        data_in,
    input  logic [MAX_NUM_WIDTH-1:0]                          max_num_in,
    input  logic                                              data_in_valid,
    output logic                                              data_in_ready,
    output logic [IN_PARALLELISM*IN_SIZE*OUT_WIDTH-1:0]       data_out,
    output logic [MAX_NUM_WIDTH-1:0]                          max_num_out,
    output logic                                              data_out_valid,
    input  logic                                              data_out_ready
);

    localparam int N      = IN_PARALLELISM * IN_SIZE;
    localparam int BEATS  = N / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = IN_WIDTH + MAX_NUM_WIDTH + 1;

    localparam logic [CNT_W-1:0]         LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic signed [PROD_W-1:0] ROUND_C   = PROD_W'(1) << (IN_WIDTH - 2);
    localparam logic signed [PROD_W-1:0] SAT_MAX   = (PROD_W'(1) << (OUT_WIDTH - 1)) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] SAT_MIN   = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         alive_q;
    logic [N*IN_WIDTH-1:0]        qlat_q, qlat_d;
    logic [MAX_NUM_WIDTH-1:0]     mlat_q, mlat_d;
    logic [N*OUT_WIDTH-1:0]       dout_q, dout_d;
    logic [MAX_NUM_WIDTH-1:0]     mout_q, mout_d;
    logic [LANES*OUT_WIDTH-1:0]   lane_res;
    logic                         ready_w;
    logic                         valid_w;

    // Each lane rescales element cnt*LANES+l of the latched block.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [IN_WIDTH-1:0] q_el;
        logic signed [PROD_W-1:0]   q_ext;
        logic signed [PROD_W-1:0]   m_ext;
        logic signed [PROD_W-1:0]   prod;
        logic signed [PROD_W-1:0]   rnd;

        assign q_el  = qlat_q[(int'(cnt_q) * LANES + l) * IN_WIDTH +: IN_WIDTH];
        assign q_ext = {{(MAX_NUM_WIDTH + 1){q_el[IN_WIDTH-1]}}, q_el};
        assign m_ext = {{(IN_WIDTH + 1){1'b0}}, mlat_q};
        assign prod  = q_ext * m_ext;
        assign rnd   = (prod + ROUND_C) >>> (IN_WIDTH - 1);

        assign lane_res[l*OUT_WIDTH +: OUT_WIDTH] =
            (rnd > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] :
            (rnd < SAT_MIN) ? SAT_MIN[OUT_WIDTH-1:0] :
                              rnd[OUT_WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qlat_d  = qlat_q;
        mlat_d  = mlat_q;
        dout_d  = dout_q;
        mout_d  = mout_q;
        ready_w = 1'b0;
        valid_w = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_w = alive_q;
            end
            S_COMPUTE: begin
                for (int l = 0; l < LANES; l++) begin
                    dout_d[(int'(cnt_q) * LANES + l) * OUT_WIDTH +: OUT_WIDTH] =
                        lane_res[l*OUT_WIDTH +: OUT_WIDTH];
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BEAT) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    mout_d  = mlat_q;
                end
            end
            S_DONE: begin
                valid_w = 1'b1;
                ready_w = data_out_ready;
                if (data_out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept overrides the DONE->IDLE exit so a drain and a load share one edge.
        if (data_in_valid && ready_w) begin
            qlat_d  = data_in;
            mlat_d  = max_num_in;
            cnt_d   = '0;
            state_d = S_COMPUTE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            alive_q <= 1'b0;
            qlat_q  <= '0;
            mlat_q  <= '0;
            dout_q  <= '0;
            mout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alive_q <= 1'b1;
            qlat_q  <= qlat_d;
            mlat_q  <= mlat_d;
            dout_q  <= dout_d;
            mout_q  <= mout_d;
        end
    end

    assign data_in_ready  = ready_w;
    assign data_out_valid = valid_w;
    assign data_out       = dout_q;
    assign max_num_out    = mout_q;

endmodule
`default_nettype wire
